move_list_sequencer: RTL and testbench

MOVE_LIST_SEQUENCER -- requirements
Module: move_list_sequencer

---
 rtl/move_list_sequencer.sv | 138 +++++++++++++
 tb/tb_move_list_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_list_sequencer.sv
// Scans the board for side-to-move pieces and emits each legal target as a (from,to,pt) move.
// Latency: one cycle per scanned square, one for evaluation and one per move; move_ready low stalls EMIT with all move_* outputs held.
module move_list_sequencer (
  input  logic        clock,
  input  logic        initialize,
  input  logic        start,
  input  logic        side_to_move,
  input  logic [63:0] is_occupied_wires,
  input  logic [63:0] occupying_piece_color,
  output logic [5:0]  pt_req_square,
  input  logic [3:0]  pt_rsp,
  output logic [5:0]  square_currently_calculating,
  output logic [3:0]  pt_calc,
  input  logic [63:0] move_wires,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic [3:0]  move_pt,
  output logic        busy,
  output logic        done,
  output logic [7:0]  move_count
);

  typedef enum logic [2:0] {IDLE, SCAN, EVAL, EMIT, DONE} state_t;

  state_t      r_state;
  logic [5:0]  r_sq_idx;
  logic        r_side;
  logic [3:0]  r_pt;
  logic [63:0] r_targets;
  logic [7:0]  r_count;
  logic        r_done;
  logic        r_busy;

  logic [63:0] w_own_mask;
  logic [63:0] w_eval_targets;
  logic [63:0] w_targets_next;
  logic        w_qualify;
  logic        w_last_sq;
  state_t      w_adv_state;
  logic [5:0]  w_adv_sq;
  logic [5:0]  w_lsb;

  assign w_own_mask     = r_side ? occupying_piece_color : ~occupying_piece_color;
  assign w_eval_targets = move_wires & ~(is_occupied_wires & w_own_mask);
  assign w_targets_next = r_targets & (r_targets - 64'd1);
  assign w_qualify      = is_occupied_wires[r_sq_idx]
                       && (occupying_piece_color[r_sq_idx] == r_side)
                       && (pt_rsp != 4'd0);

  // Moving past the current square: finish after 63, otherwise scan the next one.
  assign w_last_sq   = (r_sq_idx == 6'd63);
  assign w_adv_state = w_last_sq ? DONE : SCAN;
  assign w_adv_sq    = w_last_sq ? r_sq_idx : r_sq_idx + 6'd1;

  always_comb begin
    w_lsb = 6'd0;
    for (int i = 63; i >= 0; i--) begin
      if (r_targets[i]) w_lsb = 6'(i);
    end
  end

  always_ff @(posedge clock or posedge initialize) begin
    if (initialize) begin
      r_state   <= IDLE;
      r_sq_idx  <= 6'd0;
      r_side    <= 1'b0;
      r_pt      <= 4'd0;
      r_targets <= 64'd0;
      r_count   <= 8'd0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sq_idx <= 6'd0;
            r_count  <= 8'd0;
            r_side   <= side_to_move;
            r_busy   <= 1'b1;
            r_state  <= SCAN;
          end
        end
        SCAN: begin
          if (w_qualify) begin
            r_pt    <= pt_rsp;
            r_state <= EVAL;
          end else begin
            r_sq_idx <= w_adv_sq;
            r_done   <= w_last_sq;
            r_state  <= w_adv_state;
          end
        end
        EVAL: begin
          if (w_eval_targets == 64'd0) begin
            r_sq_idx <= w_adv_sq;
            r_done   <= w_last_sq;
            r_state  <= w_adv_state;
          end else begin
            r_targets <= w_eval_targets;
            r_state   <= EMIT;
          end
        end
        EMIT: begin
          if (move_ready) begin
            r_targets <= w_targets_next;
            if (r_count != 8'hFF) r_count <= r_count + 8'd1;
            if (w_targets_next == 64'd0) begin
              r_sq_idx <= w_adv_sq;
              r_done   <= w_last_sq;
              r_state  <= w_adv_state;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pt_req_square                = r_sq_idx;
  assign square_currently_calculating = r_sq_idx;
  assign pt_calc                      = (r_state == EVAL) ? r_pt : 4'd0;
  assign move_valid                   = (r_state == EMIT);
  assign move_from                    = r_sq_idx;
  assign move_to                      = w_lsb;
  assign move_pt                      = r_pt;
  assign busy                         = r_busy;
  assign done                         = r_done;
  assign move_count                   = r_count;

endmodule

// File: tb/tb_move_list_sequencer.sv
// Directed bench for move_list_sequencer with a board/engine model and a move scoreboard.
module tb_move_list_sequencer;

  logic        clock = 1'b0;
  logic        initialize;
  logic        start;
  logic        side_to_move;
  logic [63:0] is_occupied_wires;
  logic [63:0] occupying_piece_color;
  logic [5:0]  pt_req_square;
  logic [3:0]  pt_rsp;
  logic [5:0]  square_currently_calculating;
  logic [3:0]  pt_calc;
  logic [63:0] move_wires;
  logic        move_valid;
  logic        move_ready;
  logic [5:0]  move_from;
  logic [5:0]  move_to;
  logic [3:0]  move_pt;
  logic        busy;
  logic        done;
  logic [7:0]  move_count;

  logic [3:0]  pt_tbl  [64];
  logic [63:0] eng_tbl [64];
  logic [15:0] exp_q [$];

  int n_assert = 0;
  int n_fail = 0;
  int done_pulses = 0;
  int moves_seen = 0;

  always #5 clock = ~clock;

  assign pt_rsp     = pt_tbl[pt_req_square];
  assign move_wires = eng_tbl[square_currently_calculating];

  move_list_sequencer dut (
    .clock                        (clock),
    .initialize                   (initialize),
    .start                        (start),
    .side_to_move                 (side_to_move),
    .is_occupied_wires            (is_occupied_wires),
    .occupying_piece_color        (occupying_piece_color),
    .pt_req_square                (pt_req_square),
    .pt_rsp                       (pt_rsp),
    .square_currently_calculating (square_currently_calculating),
    .pt_calc                      (pt_calc),
    .move_wires                   (move_wires),
    .move_valid                   (move_valid),
    .move_ready                   (move_ready),
    .move_from                    (move_from),
    .move_to                      (move_to),
    .move_pt                      (move_pt),
    .busy                         (busy),
    .done                         (done),
    .move_count                   (move_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every accepted move must match the next expected entry.
  always @(negedge clock) begin
    if (done) done_pulses++;
    if (move_valid && move_ready) begin
      moves_seen++;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL unexpected_move: observed %0h expected none", {move_from, move_to, move_pt});
      end else begin
        check("move", {48'd0, move_from, move_to, move_pt}, {48'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_board();
    is_occupied_wires     = 64'd0;
    occupying_piece_color = 64'd0;
    for (int i = 0; i < 64; i++) begin
      pt_tbl[i]  = 4'd0;
      eng_tbl[i] = 64'd0;
    end
  endtask

  task automatic place(input int sq, input logic white, input logic [3:0] pt, input logic [63:0] eng);
    is_occupied_wires[sq]     = 1'b1;
    occupying_piece_color[sq] = white;
    pt_tbl[sq]                = pt;
    eng_tbl[sq]               = eng;
  endtask

  task automatic push(input int from, input int to, input int pt);
    logic [5:0] f;
    logic [5:0] t;
    logic [3:0] p;
    f = 6'(from);
    t = 6'(to);
    p = 4'(pt);
    exp_q.push_back({f, t, p});
  endtask

  // Start is sampled at the edge inside this task; returns just after that edge.
  task automatic run_start(input logic side);
    side_to_move = side;
    done_pulses  = 0;
    moves_seen   = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Counts edges after the start-sampling edge until done is observed.
  task automatic wait_done(input string tag, output int n);
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      cyc();
      if (done) begin
        n = k;
        break;
      end
    end
    if (n == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_timeout: observed no done expected done within 300 cycles", tag);
    end else begin
      cyc();
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      check({tag, "_idle_not_busy"}, 64'(busy), 64'd0);
    end
  endtask

  task automatic wait_valid(input string tag);
    int ok;
    ok = 0;
    for (int k = 0; k < 200; k++) begin
      if (move_valid) begin
        ok = 1;
        break;
      end
      cyc();
    end
    check({tag, "_valid_seen"}, 64'(ok), 64'd1);
  endtask

  initial begin
    int n;
    int hold_ok;
    initialize   = 1'b1;
    start        = 1'b0;
    side_to_move = 1'b1;
    move_ready   = 1'b1;
    clear_board();
    #12;
    check("rst_move_valid", 64'(move_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_move_count", 64'(move_count), 64'd0);
    check("rst_sq", 64'(square_currently_calculating), 64'd0);
    check("rst_pt_calc", 64'(pt_calc), 64'd0);
    check("rst_move_out", {46'd0, move_from, move_to, move_pt}, 64'd0);
    @(posedge clock);
    #1 initialize = 1'b0;
    cyc();

    // Single white piece on 32 with two targets.
    clear_board();
    place(32, 1'b1, 4'd9, (64'd1 << 24) | (64'd1 << 40));
    push(32, 24, 9);
    push(32, 40, 9);
    run_start(1'b1);
    check("t1_busy", 64'(busy), 64'd1);
    wait_done("t1", n);
    check("t1_done_cycle", 64'(n), 64'd67);
    check("t1_count", 64'(move_count), 64'd2);
    check("t1_moves", 64'(moves_seen), 64'd2);
    check("t1_done_pulses", 64'(done_pulses), 64'd1);
    check("t1_sb_drained", 64'(exp_q.size()), 64'd0);

    // Only black pieces, white to move: pure scan.
    clear_board();
    place(5, 1'b0, 4'd3, (64'd1 << 13) | (64'd1 << 6));
    place(6, 1'b0, 4'd1, 64'd0);
    run_start(1'b1);
    wait_done("t2", n);
    check("t2_done_cycle", 64'(n), 64'd64);
    check("t2_count", 64'(move_count), 64'd0);
    check("t2_moves", 64'(moves_seen), 64'd0);

    // Same board, black to move: own black piece on 6 masks that target.
    push(5, 13, 3);
    run_start(1'b0);
    wait_done("t3", n);
    check("t3_count", 64'(move_count), 64'd1);
    check("t3_sb_drained", 64'(exp_q.size()), 64'd0);

    // Target on own white piece is suppressed.
    clear_board();
    place(32, 1'b1, 4'd9, (64'd1 << 33) | (64'd1 << 41));
    place(33, 1'b1, 4'd1, 64'd0);
    push(32, 41, 9);
    run_start(1'b1);
    wait_done("t4", n);
    check("t4_count", 64'(move_count), 64'd1);
    check("t4_sb_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: hold ready low five cycles during EMIT.
    clear_board();
    place(32, 1'b1, 4'd9, (64'd1 << 24) | (64'd1 << 40));
    push(32, 24, 9);
    push(32, 40, 9);
    move_ready = 1'b0;
    run_start(1'b1);
    wait_valid("t5");
    hold_ok = 1;
    for (int k = 0; k < 5; k++) begin
      if (!(move_valid && move_to == 6'd24 && move_from == 6'd32 && move_pt == 4'd9)) hold_ok = 0;
      cyc();
    end
    check("t5_stable_during_stall", 64'(hold_ok), 64'd1);
    check("t5_none_accepted", 64'(moves_seen), 64'd0);
    move_ready = 1'b1;
    wait_done("t5", n);
    check("t5_count", 64'(move_count), 64'd2);
    check("t5_moves", 64'(moves_seen), 64'd2);

    // Reset while the second move is pending.
    push(32, 24, 9);
    move_ready = 1'b0;
    run_start(1'b1);
    wait_valid("t6");
    move_ready = 1'b1;
    cyc();
    move_ready = 1'b0;
    check("t6_count_before_rst", 64'(move_count), 64'd1);
    check("t6_pending_to", 64'(move_to), 64'd40);
    #2 initialize = 1'b1;
    #1;
    check("t6_rst_valid", 64'(move_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_count", 64'(move_count), 64'd0);
    exp_q.delete();
    cyc();
    initialize = 1'b0;
    move_ready = 1'b1;
    moves_seen = 0;
    hold_ok = 1;
    for (int k = 0; k < 8; k++) begin
      if (move_valid || busy) hold_ok = 0;
      cyc();
    end
    check("t6_quiet_after_rst", 64'(hold_ok), 64'd1);
    check("t6_no_moves_after_rst", 64'(moves_seen), 64'd0);
    push(32, 24, 9);
    push(32, 40, 9);
    run_start(1'b1);
    check("t6_rescan_sq0", 64'(square_currently_calculating), 64'd0);
    wait_done("t6", n);
    check("t6_count", 64'(move_count), 64'd2);
    check("t6_done_cycle", 64'(n), 64'd67);

    // Start held high while busy, across the EMIT window.
    push(32, 24, 9);
    push(32, 40, 9);
    run_start(1'b1);
    n = 0;
    for (int k = 1; k <= 300; k++) begin
      start = (k >= 20 && k <= 40);
      cyc();
      if (done) begin
        n = k;
        break;
      end
    end
    start = 1'b0;
    check("t7_done_cycle", 64'(n), 64'd67);
    cyc();
    check("t7_back_idle", 64'(busy), 64'd0);
    check("t7_count", 64'(move_count), 64'd2);
    check("t7_moves", 64'(moves_seen), 64'd2);
    check("t7_done_pulses", 64'(done_pulses), 64'd1);
    check("t7_sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
